pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage CPU. It generates every stall and flush for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles load-use bubbles, control-flow redirects, data-memory wait states, and interrupt entry and exit sequencing. It also keeps saturating stall and flush performance counters for debug.

Parameters:
DRAIN_CYCLES, 3, cycles to hold fetch before interrupt injection so in-flight instructions retire
CNT_W, 16, width of perf counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
id_rs1  in  4  source reg 1 of instruction in ID
id_rs2  in  4  source reg 2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_reg_dst  in  4  dest reg of instruction in EX (ID/EX output)
ex_reg_wr  in  1  EX instruction writes a register
ex_wb_sel  in  1  1 = EX instruction's writeback comes from memory (load)
ex_redirect  in  1  EX resolved a taken branch, call or return (PC redirect)
ex_returni  in  1  EX instruction is returni
mem_busy  in  1  data memory not ready; MEM stage must hold
irq  in  1  external interrupt request, level
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  clear ID/EX (bubble)
ex_mem_stall  out  1  hold EX/MEM
mem_wb_flush  out  1  clear MEM/WB
int_take  out  1  one-cycle pulse: fetch loads interrupt vector, IF/ID tags interrupt
int_active  out  1  in ISR; further irq masked
stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating
flush_cnt  out  CNT_W  cycles with id_ex_flush=1, saturating

Behaviour:
- Reset: all outputs 0, state RUN, drain counter 0, irq_pend 0, counters 0. Reset mid-sequence aborts any DRAIN or ISR and returns to RUN.
- load_use is computed combinationally in the same cycle: ex_reg_wr & ex_wb_sel & ((id_uses_rs1 & id_rs1==ex_reg_dst) | (id_uses_rs2 & id_rs2==ex_reg_dst)). r0 is a normal register and gets no exemption.
- Priority, highest first. Each level suppresses all levels below it.
  1. mem_busy: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush = 1 (bubble into WB); all other flushes 0.
  2. ex_redirect: if_id_flush = 1, id_ex_flush = 1; no stalls.
  3. load_use: pc_stall = 1, if_id_stall = 1, id_ex_flush = 1; the bubble lasts exactly 1 cycle.
  4. Otherwise all controls are 0, except where the FSM overrides them.
- irq_pend is set on any cycle with irq=1 while state==RUN. It clears on the INJECT entry.
- FSM:
  - RUN -> DRAIN when irq_pend & !ex_redirect & !mem_busy. The drain counter loads DRAIN_CYCLES.
  - DRAIN: pc_stall = 1, if_id_flush = 1 (no new fetch enters). The counter decrements only on cycles with mem_busy=0. If ex_redirect occurs during DRAIN, its flush applies and the drain continues. At counter==1 with !mem_busy, go to INJECT.
  - INJECT: int_take = 1 for exactly one cycle; no stall. Next state is ISR.
  - ISR: int_active = 1; normal hazard handling; irq is ignored. On ex_returni & !mem_busy, go to RUN. The returni redirect is the caller's ex_redirect.
- FSM outputs are ORed into the priority outputs, except under mem_busy, which freezes the FSM and overrides everything.
- Deasserting irq during DRAIN does not cancel the sequence; injection still occurs.
- Counters increment by 1 per qualifying cycle and hold at all-ones.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum RUN/DRAIN/INJECT/ISR (2 bits);
  - REG_ADDR_W = 4;
  - the default DRAIN_CYCLES constant.
- One sub-module, load_use_detect: purely combinational, computes load_use from the ID/EX operand fields.

Test Plan:
- Load-use: load with ex_reg_dst=5, ex_wb_sel=1, ex_reg_wr=1; id_rs2=5, id_uses_rs2=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1. Next cycle (ex_wb_sel=0) all 0. stall_cnt=1, flush_cnt=1.
- Redirect plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
- mem_busy=1 for 3 cycles while ex_redirect=1 -> 3 cycles of all stalls and mem_wb_flush=1 with no if_id_flush. On the cycle mem_busy falls, if_id_flush=id_ex_flush=1.
- irq pulse for 1 cycle in RUN -> DRAIN for 3 cycles (pc_stall, if_id_flush), then int_take=1 for exactly 1 cycle, then int_active=1. A second irq during ISR is ignored. ex_returni -> int_active=0 next cycle.
- mem_busy=1 for 2 cycles inside DRAIN -> int_take is delayed by exactly 2 cycles.
- rst=1 during ISR -> next cycle int_active=0, all outputs 0, counters 0. Saturation check: hold load_use for 2^CNT_W+5 cycles -> stall_cnt=0xFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The controller's interrupt FSM states and the register-address width live here.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_INJECT = 2'd2,
    ST_ISR    = 2'd3
  } ctrl_state_t;

  localparam int REG_ADDR_W       = 4;
  localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the ID instruction and a load in EX.
// r0 is an ordinary register here, so a match on address 0 still raises the hazard.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_reg_dst,
  input  logic                  ex_reg_wr,
  input  logic                  ex_wb_sel,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_reg_dst);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_reg_dst);
  assign load_use = ex_reg_wr && ex_wb_sel && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline, including interrupt
// drain/inject/return sequencing and saturating stall and flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_reg_dst,
  input  logic                  ex_reg_wr,
  input  logic                  ex_wb_sel,
  input  logic                  ex_redirect,
  input  logic                  ex_returni,
  input  logic                  mem_busy,
  input  logic                  irq,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  mem_wb_flush,
  output logic                  int_take,
  output logic                  int_active,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [1:0]            fsm_state
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  ctrl_state_t   state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_cnt_nxt;
  logic          irq_pend, irq_pend_nxt;
  logic          load_use;
  logic          fsm_pc_stall, fsm_if_id_flush, fsm_take, fsm_active;

  load_use_detect u_lud (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_reg_dst  (ex_reg_dst),
    .ex_reg_wr   (ex_reg_wr),
    .ex_wb_sel   (ex_wb_sel),
    .load_use    (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      irq_pend  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      irq_pend  <= irq_pend_nxt;
      if (pc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (id_ex_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // A busy data memory freezes the sequence: no drain progress, no state change.
  always_comb begin
    state_nxt       = state;
    drain_cnt_nxt   = drain_cnt;
    irq_pend_nxt    = irq_pend | (irq && (state == ST_RUN));
    fsm_pc_stall    = 1'b0;
    fsm_if_id_flush = 1'b0;
    fsm_take        = 1'b0;
    fsm_active      = 1'b0;
    case (state)
      ST_RUN: begin
        if (irq_pend && !ex_redirect && !mem_busy) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = DW'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        fsm_pc_stall    = 1'b1;
        fsm_if_id_flush = 1'b1;
        if (!mem_busy) begin
          if (drain_cnt == DW'(1)) begin
            state_nxt    = ST_INJECT;
            irq_pend_nxt = 1'b0;
          end else begin
            drain_cnt_nxt = drain_cnt - DW'(1);
          end
        end
      end
      ST_INJECT: begin
        fsm_take = 1'b1;
        if (!mem_busy) state_nxt = ST_ISR;
      end
      ST_ISR: begin
        fsm_active = 1'b1;
        if (ex_returni && !mem_busy) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    int_take     = 1'b0;
    int_active   = 1'b0;
    if (!rst) begin
      int_active = fsm_active;
      if (mem_busy) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else begin
        if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
        pc_stall    = pc_stall | fsm_pc_stall;
        if_id_flush = if_id_flush | fsm_if_id_flush;
        int_take    = fsm_take;
      end
    end
  end

  assign fsm_state = state;

endmodule
